// File: rtl/adc_uart_streamer.sv
// ADC sample FIFO feeding a UART 8N1 transmitter, with a sticky overflow flag for dropped samples.
// Define ADC_UART_HEX_EN to send each sample as two ASCII hex digits followed by a line feed.
module adc_uart_streamer #(
  parameter int ADC_WIDTH       = 8,
  parameter int CLK_DIV         = 434,
  parameter int FIFO_DEPTH_BITS = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [ADC_WIDTH-1:0]       sample_in,
  input  logic                       sample_valid,
  input  logic                       tx_enable,
  input  logic                       clr_ovf,
  output logic                       uart_tx,
  output logic                       busy,
  output logic [FIFO_DEPTH_BITS:0]   fifo_level,
  output logic                       overflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int CW    = $clog2(CLK_DIV);
  localparam int PW    = FIFO_DEPTH_BITS + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     byte_q, byte_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           ovf_q, ovf_d;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [7:0]     mem_q [DEPTH];
  logic [PW-1:0]  level_s;
  logic           full_s, push_s, drop_s, pop_s, bit_end_s;
  logic [7:0]     ext_s, head_s;

`ifdef ADC_UART_HEX_EN
  logic [1:0]     chr_q, chr_d;
  logic [7:0]     samp_q, samp_d;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction
`endif

  assign level_s   = wr_ptr_q - rd_ptr_q;
  assign full_s    = (level_s == PW'(DEPTH));
  assign push_s    = sample_valid & ~full_s;
  assign drop_s    = sample_valid & full_s;
  assign head_s    = mem_q[rd_ptr_q[FIFO_DEPTH_BITS-1:0]];
  assign bit_end_s = (cnt_q == CW'(CLK_DIV - 1));

  assign uart_tx    = tx_q;
  assign busy       = busy_q;
  assign fifo_level = level_s;
  assign overflow   = ovf_q;

  // Zero-extend the sample to a full byte.
  always_comb begin
    ext_s = 8'h00;
    ext_s[ADC_WIDTH-1:0] = sample_in;
  end

  // Sample storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[FIFO_DEPTH_BITS-1:0]] <= ext_s;
    end
  end

  // Drop detection uses the level before this edge, so a same-cycle pop cannot save the sample.
  always_comb begin
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Transmit FSM: next state, baud counter and line value.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    byte_d  = byte_q;
    pop_s   = 1'b0;
    tx_d    = 1'b1;
`ifdef ADC_UART_HEX_EN
    chr_d   = chr_q;
    samp_d  = samp_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
`ifdef ADC_UART_HEX_EN
        // A pending character finishes the sequence regardless of tx_enable.
        if (chr_q != 2'd0) begin
          byte_d  = (chr_q == 2'd1) ? hex_char(samp_q[3:0]) : 8'h0A;
          chr_d   = (chr_q == 2'd1) ? 2'd2 : 2'd0;
          state_d = START;
        end else if (tx_enable && (level_s != '0)) begin
          pop_s   = 1'b1;
          samp_d  = head_s;
          byte_d  = hex_char(head_s[7:4]);
          chr_d   = 2'd1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
`else
        if (tx_enable && (level_s != '0)) begin
          pop_s   = 1'b1;
          byte_d  = head_s;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
`endif
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end_s) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        tx_d = byte_q[bit_q];
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_end_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef ADC_UART_HEX_EN
    busy_d = (state_d != IDLE) || (chr_d != 2'd0);
`else
    busy_d = (state_d != IDLE);
`endif
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      byte_q   <= 8'h00;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
`ifdef ADC_UART_HEX_EN
      chr_q    <= 2'd0;
      samp_q   <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
      rd_ptr_q <= pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
`ifdef ADC_UART_HEX_EN
      chr_q    <= chr_d;
      samp_q   <= samp_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_uart_streamer.sv
// Scoreboard bench for adc_uart_streamer: stimulus queues expected bytes, a UART receiver pops and compares.
module tb_adc_uart_streamer;

  localparam int DIV = 4;
`ifdef ADC_UART_HEX_EN
  localparam int FPS      = 3;
  localparam int BUSY_LEN = 122;
`else
  localparam int FPS      = 1;
  localparam int BUSY_LEN = 40;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] sample_in;
  logic       sample_valid, tx_enable, clr_ovf;
  logic       uart_tx, busy, overflow;
  logic [2:0] fifo_level;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  bit mon_en = 1'b1;
  logic [7:0] exp_q[$];
  int starts_q[$];

  adc_uart_streamer #(.ADC_WIDTH(8), .CLK_DIV(DIV), .FIFO_DEPTH_BITS(2)) dut (
    .clk(clk), .rstn(rstn), .sample_in(sample_in), .sample_valid(sample_valid),
    .tx_enable(tx_enable), .clr_ovf(clr_ovf), .uart_tx(uart_tx), .busy(busy),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    hexc = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h41 + {4'h0, n} - 8'd10);
  endfunction

  task automatic exp_sample(input logic [7:0] s);
`ifdef ADC_UART_HEX_EN
    exp_q.push_back(hexc(s[7:4]));
    exp_q.push_back(hexc(s[3:0]));
    exp_q.push_back(8'h0A);
`else
    exp_q.push_back(s);
`endif
  endtask

  task automatic push(input logic [7:0] s);
    @(negedge clk);
    sample_in = s;
    sample_valid = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (!busy && fifo_level == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, int'(ok), 1);
  endtask

  // UART receiver: samples each bit mid-cell on the falling clock edge.
  initial begin : monitor
    logic prev_line = 1'b1;
    logic [7:0] rx;
    logic start_b, stop_b;
    bit abort;
    forever begin
      @(negedge clk);
      if (mon_en && rstn && prev_line && !uart_tx) begin
        starts_q.push_back(cyc);
        abort = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        start_b = uart_tx;
        if (!mon_en || !rstn) abort = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          rx[i] = uart_tx;
          if (!mon_en || !rstn) abort = 1'b1;
        end
        repeat (DIV) @(negedge clk);
        stop_b = uart_tx;
        if (!mon_en || !rstn) abort = 1'b1;
        if (!abort) begin
          chk("start_bit", int'(start_b), 0);
          chk("stop_bit", int'(stop_b), 1);
          chk("rx_frame_expected", int'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("rx_byte", int'(rx), int'(exp_q.pop_front()));
        end
      end
      prev_line = uart_tx;
    end
  end

  initial begin : stim
    int bc, maxlvl;
    bit seen;
    rstn = 1'b0; sample_in = 8'h00; sample_valid = 1'b0; tx_enable = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx", int'(uart_tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_ovf", int'(overflow), 0);
    rstn = 1'b1;
    tx_enable = 1'b1;
    repeat (2) @(negedge clk);

    // Single sample 0xA5: latency and busy length.
    push(8'hA5);
    exp_sample(8'hA5);
    @(negedge clk); sample_valid = 1'b0;
    chk("single_level1", int'(fifo_level), 1);
    chk("single_busy_pre", int'(busy), 0);
    chk("single_tx_idle", int'(uart_tx), 1);
    @(negedge clk);
    chk("single_busy_pop", int'(busy), 1);
    chk("single_level0", int'(fifo_level), 0);
    chk("single_tx_pre_start", int'(uart_tx), 1);
    @(negedge clk);
    chk("single_start_latency", int'(uart_tx), 0);
    bc = 2;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!busy) break;
      bc++;
    end
    chk("single_busy_len", bc, BUSY_LEN);
    wait_idle("single_idle");
    repeat (5) @(negedge clk);

    // Back-to-back burst 0x01, 0x02, 0x03.
    starts_q.delete();
    maxlvl = 0;
    push(8'h01); exp_sample(8'h01);
    push(8'h02); exp_sample(8'h02);
    push(8'h03); exp_sample(8'h03);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sample_valid = 1'b0;
      if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
    end
    chk("burst_peak_level", maxlvl, 2);
    wait_idle("burst_idle");
    repeat (10) @(negedge clk);
    chk("burst_frames", starts_q.size(), 3 * FPS);
    for (int i = 1; i < starts_q.size(); i++) chk("burst_frame_period", starts_q[i] - starts_q[i-1], 10 * DIV + 1);

    // Overflow with transmitter held off.
    @(negedge clk); tx_enable = 1'b0;
    push(8'h10); exp_sample(8'h10);
    push(8'h20); exp_sample(8'h20);
    push(8'h30); exp_sample(8'h30);
    push(8'h40); exp_sample(8'h40);
    push(8'h50);
    chk("ovf_level_full", int'(fifo_level), 4);
    chk("ovf_not_yet", int'(overflow), 0);
    @(negedge clk); sample_valid = 1'b0;
    chk("ovf_level_after_drop", int'(fifo_level), 4);
    chk("ovf_set", int'(overflow), 1);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    push(8'h60); clr_ovf = 1'b1;
    @(negedge clk); sample_valid = 1'b0; clr_ovf = 1'b0;
    chk("ovf_set_wins", int'(overflow), 1);
    chk("ovf_level_hold", int'(fifo_level), 4);
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_cleared2", int'(overflow), 0);
    tx_enable = 1'b1;
    wait_idle("ovf_drain");
    repeat (10) @(negedge clk);

    // tx_enable dropped mid-frame.
    push(8'h5A); exp_sample(8'h5A);
    push(8'hC3);
    @(negedge clk); sample_valid = 1'b0;
    repeat (12) @(negedge clk);
    tx_enable = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("txen_frame_done", int'(busy), 0);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (busy || !uart_tx) seen = 1'b1;
    end
    chk("txen_no_new_frame", int'(seen), 0);
    chk("txen_level_held", int'(fifo_level), 1);
    exp_sample(8'hC3);
    tx_enable = 1'b1;
    wait_idle("txen_resume");
    repeat (10) @(negedge clk);

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    push(8'h77);
    push(8'h78);
    @(negedge clk); sample_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst_busy_before", int'(busy), 1);
    chk("midrst_level_before", int'(fifo_level), 1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_tx", int'(uart_tx), 1);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_level", int'(fifo_level), 0);
    chk("midrst_ovf", int'(overflow), 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (50) @(negedge clk);
    chk("postrst_tx", int'(uart_tx), 1);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Sample 0x3C: raw byte, or '3','C',LF in hex mode.
`ifdef ADC_UART_HEX_EN
    push(8'h3C);
    exp_q.push_back(8'h33); exp_q.push_back(8'h43); exp_q.push_back(8'h0A);
`else
    push(8'h3C);
    exp_q.push_back(8'h3C);
`endif
    @(negedge clk); sample_valid = 1'b0;
    chk("s3c_level1", int'(fifo_level), 1);
    @(negedge clk);
    chk("s3c_level0", int'(fifo_level), 0);
    wait_idle("s3c_idle");
    repeat (10) @(negedge clk);

    chk("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
